// File: rtl/mod_counter_p_pkg.sv
// Shared constants and helpers for the modulo up/down counter.
// Imported by the interface, the prescaler and the counter top.
package counter_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 11;
  localparam int DEF_MAX     = DEF_MODULUS - 1;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  // Width of the prescaler phase register; at least one bit.
  function automatic int pre_width(input int p);
    return (p <= 2) ? 1 : $clog2(p);
  endfunction

  function automatic int max_count(input int m);
    return m - 1;
  endfunction

endpackage

// File: rtl/mod_counter_p_if.sv
// Control and status bundle of the modulo counter.
// master drives controls, slave is the counter itself.
interface mod_counter_p_if
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ovf_clr;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up, clr, load,
    output load_val, ovf_clr,
    input  count, tc, ovf
  );

  modport slave (
    input  en, up, clr, load,
    input  load_val, ovf_clr,
    output count, tc, ovf
  );

endinterface

// File: rtl/mod_counter_p_tick_gen.sv
// Prescaler: one tick every PRESCALE enabled cycles.
// sync_rst restarts the phase; en=0 freezes it.
module tick_gen
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_rst,
  output logic tick
);

  if (PRESCALE == 1) begin : g_direct
    logic unused_ok;
    assign unused_ok = ^{clk, rst, sync_rst};
    assign tick = en;
  end else begin : g_pre
    localparam int PW = pre_width(PRESCALE);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    assign tick = en && (pre == PMAX);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pre <= '0;
      end else if (sync_rst) begin
        pre <= '0;
      end else if (en) begin
        pre <= tick ? '0 : pre + PW'(1);
      end
    end
  end

endmodule

// File: rtl/mod_counter_p.sv
// Parametrised modulo up/down counter with prescaler,
// wrap/saturate mode, terminal-count pulse and sticky overflow.
module mod_counter_p
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MODULUS  = DEF_MODULUS,
  parameter int PRESCALE = 1,
  parameter int SATURATE = int'(MODE_WRAP)
) (
  input  logic            clk,
  input  logic            rst,
  mod_counter_p_if.slave  bus
);

  if (WIDTH < 1 || MODULUS < 2 || PRESCALE < 1 ||
      (SATURATE != 0 && SATURATE != 1) ||
      (WIDTH < 31 && MODULUS > (1 << WIDTH))) begin : g_bad_param
    $error("mod_counter_p: illegal parameters");
  end

  localparam logic [WIDTH-1:0] MAX =
    WIDTH'(max_count(MODULUS));
  localparam bit SAT = (SATURATE == int'(MODE_SAT));

  logic             tick;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             bnd;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .sync_rst (bus.clr | bus.load),
    .tick     (tick)
  );

  always_comb begin
    cnt_d = cnt_q;
    bnd   = 1'b0;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (bus.load) begin
      cnt_d = (bus.load_val > MAX) ? MAX : bus.load_val;
    end else if (tick) begin
      if (bus.up) begin
        if (cnt_q != MAX) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else begin
          bnd = 1'b1;
          if (!SAT) cnt_d = '0;
        end
      end else begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else begin
          bnd = 1'b1;
          if (!SAT) cnt_d = MAX;
        end
      end
    end
    tc_d  = bnd;
    // A boundary step in the same cycle as ovf_clr keeps the flag.
    ovf_d = bnd | (ovf_q & ~bus.ovf_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.count = cnt_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_mod_counter_p.sv
// Directed bench for mod_counter_p in wrap, saturate
// and prescale-3 configurations.
module tb_mod_counter_p;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 clk = ~clk;

  mod_counter_p_if #(.WIDTH(4)) b0 ();
  mod_counter_p_if #(.WIDTH(4)) b1 ();
  mod_counter_p_if #(.WIDTH(4)) b2 ();

  mod_counter_p #(
    .WIDTH(4), .MODULUS(11), .PRESCALE(1), .SATURATE(0)
  ) u0 (.clk(clk), .rst(rst), .bus(b0.slave));

  mod_counter_p #(
    .WIDTH(4), .MODULUS(11), .PRESCALE(1), .SATURATE(1)
  ) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  mod_counter_p #(
    .WIDTH(4), .MODULUS(11), .PRESCALE(3), .SATURATE(0)
  ) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  typedef struct {
    int         sel;
    bit         en;
    bit         up;
    bit         clr;
    bit         load;
    bit         oc;
    logic [3:0] lv;
    logic [3:0] c;
    bit         tc;
    bit         ovf;
    string      nm;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input int s, input bit en, input bit up,
    input bit clr, input bit load, input bit oc,
    input logic [3:0] lv, input logic [3:0] c,
    input bit tc, input bit ovf, input string nm
  );
    vec_t r;
    r.sel = s; r.en = en; r.up = up; r.clr = clr;
    r.load = load; r.oc = oc; r.lv = lv; r.c = c;
    r.tc = tc; r.ovf = ovf; r.nm = nm;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [3:0] a,
                     input logic [3:0] e);
    ntests++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d", nm, a, e);
    end
  endtask

  task automatic idle_all();
    b0.en = 0; b0.up = 0; b0.clr = 0; b0.load = 0;
    b0.load_val = 0; b0.ovf_clr = 0;
    b1.en = 0; b1.up = 0; b1.clr = 0; b1.load = 0;
    b1.load_val = 0; b1.ovf_clr = 0;
    b2.en = 0; b2.up = 0; b2.clr = 0; b2.load = 0;
    b2.load_val = 0; b2.ovf_clr = 0;
  endtask

  task automatic run(input vec_t t, input int idx);
    logic [3:0] ac;
    logic       at;
    logic       ao;
    string      nm;
    idle_all();
    case (t.sel)
      0: begin
        b0.en = t.en; b0.up = t.up; b0.clr = t.clr;
        b0.load = t.load; b0.load_val = t.lv;
        b0.ovf_clr = t.oc;
      end
      1: begin
        b1.en = t.en; b1.up = t.up; b1.clr = t.clr;
        b1.load = t.load; b1.load_val = t.lv;
        b1.ovf_clr = t.oc;
      end
      default: begin
        b2.en = t.en; b2.up = t.up; b2.clr = t.clr;
        b2.load = t.load; b2.load_val = t.lv;
        b2.ovf_clr = t.oc;
      end
    endcase
    @(posedge clk);
    #1;
    case (t.sel)
      0: begin ac = b0.count; at = b0.tc; ao = b0.ovf; end
      1: begin ac = b1.count; at = b1.tc; ao = b1.ovf; end
      default: begin
        ac = b2.count; at = b2.tc; ao = b2.ovf;
      end
    endcase
    nm = $sformatf("%s[%0d]", t.nm, idx);
    chk({nm, ".count"}, ac, t.c);
    chk({nm, ".tc"}, 4'(at), 4'(t.tc));
    chk({nm, ".ovf"}, 4'(ao), 4'(t.ovf));
  endtask

  initial begin
    // wrap count 0..10 on the default instance
    for (int k = 1; k <= 10; k++)
      tv.push_back(mk(0,1,1,0,0,0,0, 4'(k),0,0,"t1"));
    tv.push_back(mk(0,1,1,0,0,0,0, 0,1,1,"t1"));
    tv.push_back(mk(0,1,1,0,0,0,0, 1,0,1,"t1"));
    // saturate up, blocked steps, then down
    tv.push_back(mk(1,0,0,0,1,0,9,  9,0,0,"t2"));
    tv.push_back(mk(1,1,1,0,0,0,0, 10,0,0,"t2"));
    tv.push_back(mk(1,1,1,0,0,0,0, 10,1,1,"t2"));
    tv.push_back(mk(1,1,1,0,0,0,0, 10,1,1,"t2"));
    tv.push_back(mk(1,1,0,0,0,0,0,  9,0,1,"t2"));
    tv.push_back(mk(1,1,0,0,0,0,0,  8,0,1,"t2"));
    tv.push_back(mk(1,0,0,0,1,1,0,  0,0,0,"t2"));
    tv.push_back(mk(1,1,0,0,0,0,0,  0,1,1,"t2"));
    // prescale 3 with an en gap mid-period
    tv.push_back(mk(2,1,1,0,0,0,0, 0,0,0,"t3"));
    tv.push_back(mk(2,1,1,0,0,0,0, 0,0,0,"t3"));
    tv.push_back(mk(2,1,1,0,0,0,0, 1,0,0,"t3"));
    tv.push_back(mk(2,1,1,0,0,0,0, 1,0,0,"t3"));
    tv.push_back(mk(2,0,1,0,0,0,0, 1,0,0,"t3"));
    tv.push_back(mk(2,0,1,0,0,0,0, 1,0,0,"t3"));
    tv.push_back(mk(2,1,1,0,0,0,0, 1,0,0,"t3"));
    tv.push_back(mk(2,1,1,0,0,0,0, 2,0,0,"t3"));
    tv.push_back(mk(2,1,1,0,0,0,0, 2,0,0,"t3"));
    tv.push_back(mk(2,1,1,0,0,0,0, 2,0,0,"t3"));
    tv.push_back(mk(2,1,1,0,0,0,0, 3,0,0,"t3"));
    // down wrap and ovf set/clear race
    tv.push_back(mk(0,0,0,0,0,1,0,  1,0,0,"t4"));
    tv.push_back(mk(0,0,0,1,0,0,0,  0,0,0,"t4"));
    tv.push_back(mk(0,1,0,0,0,0,0, 10,1,1,"t4"));
    tv.push_back(mk(0,1,1,0,0,1,0,  0,1,1,"t4"));
    tv.push_back(mk(0,0,0,0,0,1,0,  0,0,0,"t4"));
    // priority and load clamp
    tv.push_back(mk(0,1,1,1,1,0,5,  0,0,0,"t5"));
    tv.push_back(mk(0,0,0,0,1,0,15,10,0,0,"t5"));
    tv.push_back(mk(0,1,1,0,1,0,4,  4,0,0,"t5"));
    // set up count=7 ovf=1 and a mid-phase prescaler
    tv.push_back(mk(0,0,0,0,1,0,0,  0,0,0,"t6"));
    tv.push_back(mk(0,1,0,0,0,0,0, 10,1,1,"t6"));
    tv.push_back(mk(0,0,0,0,1,0,7,  7,0,1,"t6"));
    tv.push_back(mk(2,1,1,0,0,0,0,  3,0,0,"t6"));

    idle_all();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.count0", b0.count, 4'd0);
    chk("rst.tc0", 4'(b0.tc), 4'd0);
    chk("rst.ovf0", 4'(b0.ovf), 4'd0);
    chk("rst.count1", b1.count, 4'd0);
    chk("rst.count2", b2.count, 4'd0);
    rst = 1'b1;

    for (int i = 0; i < tv.size(); i++)
      run(tv[i], i);

    // asynchronous reset between edges
    idle_all();
    #3;
    rst = 1'b0;
    #1;
    chk("arst.count0", b0.count, 4'd0);
    chk("arst.tc0", 4'(b0.tc), 4'd0);
    chk("arst.ovf0", 4'(b0.ovf), 4'd0);
    chk("arst.count2", b2.count, 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run(mk(2,1,1,0,0,0,0, 0,0,0,"rel"), 0);
    run(mk(2,1,1,0,0,0,0, 0,0,0,"rel"), 1);
    run(mk(2,1,1,0,0,0,0, 1,0,0,"rel"), 2);
    run(mk(0,1,1,0,0,0,0, 1,0,0,"rel"), 3);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
